sdiv_seq: RTL

- Multi-cycle signed integer divider, parameterised on DATAWIDTH. It is the inverse operation of the datapath's combinational signed multiplier.
- Produces a truncated quotient and remainder using a restoring shift-subtract algorithm on operand magnitudes, followed by sign correction.
- Used by scheduled datapaths where a divide may take many cycles. Controlled by a start/busy/done handshake.

---
 rtl/sdiv_seq_if.sv | 23 ++
 rtl/sdiv_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sdiv_seq_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential signed divider.
interface sdiv_seq_if #(
  parameter int unsigned DATAWIDTH = 64
) ();
  logic                 start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] quot;
  logic [DATAWIDTH-1:0] rem;
  logic                 busy;
  logic                 done;
  logic                 dbz;

  modport master (
    output start, a, b,
    input  quot, rem, busy, done, dbz
  );

  modport slave (
    input  start, a, b,
    output quot, rem, busy, done, dbz
  );
endinterface

// File: rtl/sdiv_seq.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes, then sign fix-up.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module sdiv_seq #(
  parameter int unsigned DATAWIDTH = 64
) (
  input  logic       Clk,
  input  logic       Rst,
  sdiv_seq_if.slave  bus
);
  localparam int unsigned CntW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic                 zero_q, zero_d, done_q, done_d, dbz_q, dbz_d;
  logic [DATAWIDTH:0]   mag_b_q, mag_b_d, r_q, r_d;
  logic [DATAWIDTH-1:0] q_q, q_d, quot_q, quot_d, rem_q, rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [DATAWIDTH:0]   a_ext, b_ext, abs_a, abs_b, r_shift, diff;
  logic                 accept;

  // Magnitudes are one bit wider so that |most negative| is exact.
  always_comb begin
    a_ext   = {bus.a[DATAWIDTH-1], bus.a};
    b_ext   = {bus.b[DATAWIDTH-1], bus.b};
    abs_a   = a_ext[DATAWIDTH] ? -a_ext : a_ext;
    abs_b   = b_ext[DATAWIDTH] ? -b_ext : b_ext;
    r_shift = {r_q[DATAWIDTH-1:0], q_q[DATAWIDTH-1]};
    diff    = r_shift - mag_b_q;
    // A zero divisor never accepts, so R accumulates |a| and the dividend is recoverable.
    accept  = ~diff[DATAWIDTH] & ~zero_q;
  end

  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    zero_d   = zero_q;
    mag_b_d  = mag_b_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sign_a_d = bus.a[DATAWIDTH-1];
          sign_b_d = bus.b[DATAWIDTH-1];
          zero_d   = (bus.b == '0);
          q_d      = abs_a[DATAWIDTH-1:0];
          mag_b_d  = abs_b;
          r_d      = '0;
          cnt_d    = CntW'(DATAWIDTH);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        r_d   = accept ? diff : r_shift;
        q_d   = {q_q[DATAWIDTH-2:0], accept};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quot_d  = zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -q_q : q_q);
        rem_d   = sign_a_q ? -r_q[DATAWIDTH-1:0] : r_q[DATAWIDTH-1:0];
        dbz_d   = zero_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= StIdle;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zero_q   <= 1'b0;
      mag_b_q  <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      zero_q   <= zero_d;
      mag_b_q  <= mag_b_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  // Both MSBs are always zero by construction.
  logic unused_msbs;
  assign unused_msbs = ^{abs_a[DATAWIDTH], r_q[DATAWIDTH]};

  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
endmodule
